reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2R/1W integer register file, with a configurable number of read ports, data width and depth.
- Adds three behaviours: write-to-read bypass, a per-register pending scoreboard for the pipelined core's hazard unit, and a sequential clear engine that zeroes the array one entry per cycle on request.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of 2, at least 4); AW = $clog2(NREGS).
- NREAD, 2, number of read ports (1 to 4).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: never written, never pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NREAD*XLEN  read data, combinational; port i uses bits [i*XLEN +: XLEN].
- rd_pend  out  NREAD  port i source register has a write outstanding.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss_en  in  1  mark register iss_addr pending (instruction issued with a destination).
- iss_addr  in  AW  destination being issued.
- clr_req  in  1  single-cycle request to start a sequential clear.
- busy  out  1  clear engine active; upstream must stall writes and issues.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers 0, all pending bits 0.
  - FSM = IDLE, clear counter = 0, busy = 0.
  - Outputs are valid combinationally from this state while rst_n is low.
  - Reset asserted mid-clear aborts the clear; the array is fully zeroed by reset anyway.
- Reads (combinational, zero latency):
  - rd[i] = regs[ra_i].
  - If ZERO_REG and ra_i == 0: rd[i] = 0 and rd_pend[i] = 0.
  - Bypass hit on port i: BYPASS=1, FSM=IDLE, we=1, wa == ra_i, and not (ZERO_REG and wa == 0).
  - On a bypass hit, rd[i] = wd and rd_pend[i] = 0.
  - Otherwise rd_pend[i] = pend[ra_i].
- Write (FSM=IDLE only):
  - On the edge with we=1, regs[wa] <= wd, unless ZERO_REG and wa == 0.
  - The same edge clears pend[wa].
- Issue (FSM=IDLE only):
  - On the edge with iss_en=1, pend[iss_addr] <= 1, unless ZERO_REG and iss_addr == 0.
  - Same edge with we and iss_en to the same address: data is written and pend ends at 1 (set wins; a new producer is in flight).
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clr_req=1: next state CLEAR, counter <= 0, all pend <= 0. Any we/iss_en on that same edge is still honoured for data, but pend is cleared regardless.
  - CLEAR: busy=1. Each edge writes regs[counter] <= 0 and increments the counter.
  - When counter == NREGS-1, that edge zeroes the last entry and returns to IDLE, so busy is high for exactly NREGS cycles.
  - In CLEAR, we and iss_en are ignored (dropped, not queued) and clr_req is ignored.
  - Reads in CLEAR return current stored contents (partially cleared), with no bypass.
  - Counter is AW bits wide, and wrap-around never occurs because exit is at NREGS-1.
- Write/read collisions between ports are not possible (single write port). All read ports may address the same register simultaneously.

Test Plan:
- Reset then read ports 0/1 at x5/x31 -> rd=0, rd_pend=0, busy=0. Write x0=0xDEADBEEF (ZERO_REG=1), then read x0 -> 0.
- we=1, wa=7, wd=0x12345678 with ra0=7 in the same cycle -> rd0=0x12345678 immediately (bypass). Next cycle with we=0 -> rd0 still 0x12345678. Repeat with BYPASS=0 -> old value (0) in the write cycle.
- iss_en at x9 -> next cycle rd_pend=1 for ra=9. Write x9=0xA5 with ra=9 -> rd_pend=0 in the write cycle and 0 afterwards. Same-edge we and iss_en to x9 -> rd_pend=1 afterwards, data=new value.
- Fill x1..x31 with nonzero values, pulse clr_req -> busy high exactly 32 cycles. Mid-clear, x3 reads 0 after the cycle counter=3 and x20 still reads its value. A we to x20 during busy is dropped. After busy falls, all reads are 0 and pend is all 0.
- Assert rst_n low 5 cycles into a clear -> busy=0 immediately, all registers 0. After release, a write to x4 succeeds on the next edge.
- NREAD=4, NREGS=16, XLEN=64: all four ports read distinct and identical addresses -> correct 64-bit data and per-port rd_pend.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with write bypass,
// pending scoreboard and a sequential clear engine.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREAD*AW-1:0]   ra,
   output logic [NREAD*XLEN-1:0] rd,
   output logic [NREAD-1:0]      rd_pend,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [XLEN-1:0]       wd,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_addr,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t             state;
   logic [AW-1:0]      cnt;
   logic [XLEN-1:0]    regs [NREGS];
   logic [NREGS-1:0]   pend;

   logic               wr_ok;
   logic               iss_ok;

   assign wr_ok  = we && !(ZR && wa == '0);
   assign iss_ok = iss_en && !(ZR && iss_addr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         pend  <= '0;
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (wr_ok) regs[wa] <= wd;
               // A clear request wipes the scoreboard even if an
               // issue lands on the same edge.
               if (clr_req) begin
                  pend  <= '0;
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  if (we)     pend[wa]       <= 1'b0;
                  if (iss_ok) pend[iss_addr] <= 1'b1;
               end
            end
            CLEAR: begin
               regs[cnt] <= '0;
               cnt       <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd      = '0;
      rd_pend = '0;
      for (int i = 0; i < NREAD; i++) begin
         if (ZR && ra[i*AW +: AW] == '0) begin
            rd[i*XLEN +: XLEN] = '0;
         end else if (BP && state == IDLE && wr_ok &&
                      wa == ra[i*AW +: AW]) begin
            rd[i*XLEN +: XLEN] = wd;
         end else begin
            rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
            rd_pend[i]         = pend[ra[i*AW +: AW]];
         end
      end
   end

endmodule
